// File: rtl/kbd_common.sv
// kbd_common: shared response codes, command record and sequencer states
package kbd_common;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  typedef struct packed {
    logic       len;
    logic [7:0] byte0;
    logic [7:0] byte1;
  } kbd_cmd_t;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, LINE_ACK, WAIT_RESP, DONE} kbd_seq_state_t;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device frame shifter with line synchronizers and line-ack sample
module ps2_tx
  import kbd_common::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       data_oe,
  output logic       fall,
  output logic [3:0] bit_cnt,
  output logic       sent,
  output logic       nack
);
  logic [2:0]  clk_s;
  logic [1:0]  dat_s;
  logic [10:0] sh;
  always_ff @(posedge clk_i) begin
    clk_s <= reset_i ? 3'b111 : {clk_s[1:0], ps2_clk_i};
    dat_s <= reset_i ? 2'b11 : {dat_s[0], ps2_data_i};
    if (reset_i || load) begin
      sh      <= {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
      bit_cnt <= '0;
    end else if (en && fall) begin
      sh      <= {1'b1, sh[10:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end
  // sh[0] is the bit currently on the line: start bit first, then data, parity, stop
  assign fall    = clk_s[2] & ~clk_s[1];
  assign data_oe = en & ~sh[0];
  assign sent    = en & fall & (bit_cnt == 4'd10) & ~dat_s[1];
  assign nack    = en & fall & (bit_cnt == 4'd10) & dat_s[1];
endmodule

// File: rtl/kbd_cmd_sequencer.sv
// kbd_cmd_sequencer: sends 1-2 byte keyboard commands over PS/2 with ack/resend/timeout retry
module kbd_cmd_sequencer
  import kbd_common::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_len_i,
  input  logic [7:0] cmd_byte0_i,
  input  logic [7:0] cmd_byte1_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_consume_o,
  output logic       done_o,
  output logic       error_o
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IHW = $clog2(INHIBIT_CYCLES + 1);
  localparam int RCW = $clog2(MAX_RETRIES + 1);
  kbd_seq_state_t state, nxt;
  kbd_cmd_t       cmd;
  logic           idx, err, fall, sent, nack, expired, is_ack, is_resend, ack_more, retry;
  logic [3:0]     bit_cnt;
  logic [RCW-1:0] rc;
  logic [IHW-1:0] inh;
  logic [WDW-1:0] wd;
  ps2_tx u_tx (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load       (state == INHIBIT),
    .en         (state == RTS || state == SHIFT || state == LINE_ACK),
    .tx_byte    (idx ? cmd.byte1 : cmd.byte0),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .data_oe    (ps2_data_oe_o),
    .fall       (fall),
    .bit_cnt    (bit_cnt),
    .sent       (sent),
    .nack       (nack)
  );
  assign expired      = wd == WDW'(TIMEOUT_CYCLES);
  assign is_ack       = state == WAIT_RESP && rx_valid_i && rx_data_i == PS2_ACK;
  assign is_resend    = state == WAIT_RESP && rx_valid_i && rx_data_i == PS2_RESEND;
  assign ack_more     = is_ack & ~idx & cmd.len;
  assign rx_consume_o = is_ack | is_resend;
  always_ff @(posedge clk_i) state <= reset_i ? IDLE : nxt;
  always_comb begin
    retry = 1'b0;
    nxt   = state;
    case (state)
      IDLE:      nxt = cmd_valid_i ? INHIBIT : IDLE;
      INHIBIT:   nxt = inh == IHW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
      RTS:       if (fall) nxt = SHIFT; else retry = expired;
      SHIFT:     if (fall && bit_cnt == 4'd9) nxt = LINE_ACK; else retry = expired;
      LINE_ACK:  if (sent) nxt = WAIT_RESP; else retry = nack | expired;
      WAIT_RESP: if (is_ack) nxt = ack_more ? INHIBIT : DONE; else retry = is_resend | expired;
      default:   nxt = IDLE;
    endcase
    if (retry) nxt = rc < RCW'(MAX_RETRIES) ? INHIBIT : DONE;
  end
  always_comb begin
    cmd_ready_o  = state == IDLE;
    ps2_clk_oe_o = state == INHIBIT;
    done_o       = state == DONE;
    error_o      = done_o & err;
  end
  // watchdog restarts only when a new phase (RTS or WAIT_RESP) is entered
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd <= '0;
      idx <= 1'b0;
      rc  <= '0;
      err <= 1'b0;
      inh <= '0;
      wd  <= '0;
    end else begin
      if (state == IDLE) begin
        cmd <= '{len: cmd_len_i, byte0: cmd_byte0_i, byte1: cmd_byte1_i};
        idx <= 1'b0;
        rc  <= '0;
      end
      if (ack_more) begin
        idx <= 1'b1;
        rc  <= '0;
      end
      if (retry && nxt == INHIBIT) rc <= rc + RCW'(1);
      if (nxt == DONE) err <= retry;
      inh <= state == INHIBIT ? inh + IHW'(1) : '0;
      wd  <= (nxt != state && (nxt == RTS || nxt == WAIT_RESP)) ? '0 : wd + WDW'(!expired);
    end
  end
endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// tb_kbd_cmd_sequencer: scoreboard bench with a PS/2 device model driving directed commands
module tb_kbd_cmd_sequencer;
  localparam int INH = 20;
  localparam int HP = 4;
  logic clk = 0, reset_i = 1, cmd_valid = 0, cmd_len = 0, rx_valid = 0;
  logic [7:0] b0 = 0, b1 = 0, rx_data = 0;
  logic clk_oe, data_oe, ready, consume, done, error, ps2_clk, ps2_data;
  logic dev_clk = 1, dev_data = 1;
  bit dev_silent = 0, dev_abort = 0, dev_busy = 0;
  int dev_edges = 0, done_seen = 0, done_base = 0, inh_len = 0, inh_phases = 0;
  int checks = 0, errors = 0;
  logic [10:0] exp_frames[$];
  logic        exp_done[$];
  logic        exp_cons[$];
  logic [8:0]  resp_q[$];
  assign ps2_clk  = ~clk_oe & dev_clk;
  assign ps2_data = ~data_oe & dev_data;
  kbd_cmd_sequencer #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(200), .MAX_RETRIES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
    .cmd_len_i(cmd_len), .cmd_byte0_i(b0), .cmd_byte1_i(b1),
    .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .ps2_clk_oe_o(clk_oe), .ps2_data_oe_o(data_oe),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_consume_o(consume),
    .done_o(done), .error_o(error)
  );
  always #5 clk = ~clk;
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic unexpected(string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask
  // device: answers request-to-send, clocks 11 edges, acks the line, then plays resp_q
  initial begin
    logic [10:0] fr;
    logic [8:0]  r;
    forever begin
      @(posedge clk);
      #1;
      if (!dev_silent && data_oe && !clk_oe) begin
        dev_busy  = 1;
        dev_edges = 0;
        tick(5);
        fr[0] = ps2_data;
        for (int k = 1; k <= 11; k++) begin
          dev_clk   = 0;
          dev_edges = k;
          tick(HP);
          dev_clk = 1;
          if (k <= 10) fr[k] = ps2_data;
          if (k == 10) dev_data = 0;
          if (k == 11) dev_data = 1;
          tick(HP);
        end
        if (dev_abort) dev_abort = 0;
        else if (exp_frames.size() == 0) unexpected("frame");
        else check("frame", fr, exp_frames.pop_front());
        while (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          tick(6);
          rx_data  = r[7:0];
          rx_valid = 1;
          exp_cons.push_back(r[8]);
          tick(1);
          rx_valid = 0;
          if (r[8]) break;
        end
        dev_busy = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_cons.size() == 0) unexpected("rx_consume");
      else check("rx_consume", consume, exp_cons.pop_front());
    end
    if (done) begin
      done_seen++;
      if (exp_done.size() == 0) unexpected("done");
      else check("error", error, exp_done.pop_front());
    end
    if (clk_oe) inh_len++;
    else if (inh_len > 0) begin
      check("inhibit_len", inh_len, INH);
      inh_phases++;
      inh_len = 0;
    end
  end
  task automatic send_cmd(logic len, logic [7:0] a, logic [7:0] c);
    int t = 0;
    while (!ready && t < 2000) begin
      tick(1);
      t++;
    end
    check("cmd_ready", ready, 1);
    done_base = done_seen;
    cmd_len = len;
    b0 = a;
    b1 = c;
    cmd_valid = 1;
    tick(1);
    cmd_valid = 0;
    check("clk_oe_after_accept", clk_oe, 1);
  endtask
  task automatic wait_done();
    int t = 0;
    while (done_seen == done_base && t < 5000) begin
      tick(1);
      t++;
    end
    check("done_count", done_seen, done_base + 1);
    t = 0;
    while (dev_busy && t < 2000) begin
      tick(1);
      t++;
    end
    check("ready_after_done", ready, 1);
    check("frames_left", exp_frames.size(), 0);
  endtask
  initial begin
    int ph;
    tick(3);
    check("rst_ready", ready, 1);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_consume", consume, 0);
    reset_i = 0;
    tick(2);
    rx_data = 8'hFA;
    rx_valid = 1;
    exp_cons.push_back(1'b0);
    tick(1);
    rx_valid = 0;
    exp_frames.push_back(11'h7FE);
    resp_q.push_back({1'b1, 8'hFA});
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 8'hFF, 8'h00);
    wait_done();
    ph = inh_phases;
    exp_frames.push_back(11'h7DA);
    exp_frames.push_back(11'h40E);
    resp_q.push_back({1'b1, 8'hFA});
    resp_q.push_back({1'b1, 8'hFA});
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 8'hED, 8'h07);
    wait_done();
    check("two_byte_phases", inh_phases - ph, 2);
    ph = inh_phases;
    repeat (3) exp_frames.push_back(11'h7DA);
    resp_q.push_back({1'b1, 8'hFE});
    resp_q.push_back({1'b1, 8'hFE});
    resp_q.push_back({1'b1, 8'hFA});
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 8'hED, 8'h00);
    wait_done();
    check("resend_phases", inh_phases - ph, 3);
    ph = inh_phases;
    dev_silent = 1;
    exp_done.push_back(1'b1);
    send_cmd(1'b0, 8'hFF, 8'h00);
    wait_done();
    dev_silent = 0;
    check("timeout_phases", inh_phases - ph, 3);
    check("timeout_clk_oe", clk_oe, 0);
    check("timeout_data_oe", data_oe, 0);
    exp_frames.push_back(11'h7FE);
    resp_q.push_back({1'b0, 8'h1C});
    resp_q.push_back({1'b1, 8'hFA});
    exp_done.push_back(1'b0);
    send_cmd(1'b0, 8'hFF, 8'h00);
    wait_done();
    begin
      int t = 0;
      dev_abort = 1;
      dev_edges = 0;
      send_cmd(1'b0, 8'hFF, 8'h00);
      while (dev_edges < 4 && t < 2000) begin
        tick(1);
        t++;
      end
      check("reached_shift", dev_edges >= 4, 1);
      reset_i = 1;
      tick(1);
      reset_i = 0;
      check("mid_reset_clk_oe", clk_oe, 0);
      check("mid_reset_data_oe", data_oe, 0);
      check("mid_reset_ready", ready, 1);
      t = 0;
      while (dev_busy && t < 2000) begin
        tick(1);
        t++;
      end
      tick(30);
      check("mid_reset_no_done", done_seen, done_base);
    end
    check("exp_done_left", exp_done.size(), 0);
    check("exp_cons_left", exp_cons.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/kbd_cmd_sequencer.md
# kbd_cmd_sequencer

Host-to-keyboard command sequencer for the PS/2 port. It accepts one- or two-byte keyboard commands, such as 0xED + LED mask or 0xFF reset, from the keyboard controller's control register path. For each byte it drives the PS/2 host-to-device transmit protocol on open-drain clock/data enables, then waits for the device's 0xFA/0xFE response on the existing receive path. It retries on resend or timeout and reports completion or error.

## Interface
Parameters:
- INHIBIT_CYCLES, default 5000: cycles the clock line is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, default 1_000_000: per-phase watchdog, in cycles.
- MAX_RETRIES, default 3: resend/timeout retries allowed per byte.

Ports:
- clk_i  in  1  system clock; one clock domain.
- reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high in IDLE; transfer occurs when valid && ready.
- cmd_len_i  in  1  0 = one byte, 1 = two bytes.
- cmd_byte0_i  in  8  first command byte.
- cmd_byte1_i  in  8  second byte; ignored when cmd_len_i = 0.
- ps2_clk_i  in  1  raw PS/2 clock line; synchronized internally.
- ps2_data_i  in  1  raw PS/2 data line; synchronized internally.
- ps2_clk_oe_o  out  1  1 = pull clock line low.
- ps2_data_oe_o  out  1  1 = pull data line low.
- rx_data_i  in  8  byte from the PS/2 receiver.
- rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
- rx_consume_o  out  1  combinational. Asserted with rx_valid_i when the byte is taken as a response, so the keyboard decode path drops it.
- done_o  out  1  one-cycle pulse at command end.
- error_o  out  1  valid only with done_o; 1 = failed.

## Operation
- Command fields are latched on acceptance. Byte index idx = 0; retry count rc = 0.
- IDLE: cmd_ready_o = 1; all OE outputs = 0.
- INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles.
- RTS: data_oe = 1, clk_oe = 0. Start the watchdog. Wait for a falling edge of the synchronized clock.
- SHIFT: the bit counter advances on each synchronized falling edge.
  - Edges 1–8 present data bits d0..d7, LSB first (data_oe = ~bit).
  - Edge 9 presents odd parity.
  - Edge 10 releases data (stop bit).
- LINE_ACK: on the 11th falling edge, sample ps2_data_i.
  - 0 → WAIT_RESP, watchdog restarted.
  - 1 → treated as a timeout.
- WAIT_RESP: on rx_valid_i, act on rx_data_i:
  - 0xFA: consumed. If idx < cmd_len, set idx = 1, rc = 0, go to INHIBIT. Otherwise go to DONE with error = 0.
  - 0xFE: consumed. Retry the same byte.
  - Any other byte: not consumed; remain in WAIT_RESP.
- Retry: if rc < MAX_RETRIES, increment rc and go to INHIBIT. Otherwise go to DONE with error = 1.
- Watchdog expiry in RTS, SHIFT, LINE_ACK or WAIT_RESP follows the retry path.
- DONE: done_o = 1 for one cycle, then IDLE.
- Parity is computed as ~^byte.
- The watchdog is a counter of width $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values:
  - cmd_ready_o = 1 (state IDLE).
  - ps2_clk_oe_o, ps2_data_oe_o = 0.
  - done_o, error_o, rx_consume_o = 0.
- Reset asserted mid-command: both lines are released on the next edge; no done_o is produced.
- Input synchronizer is two flops. The falling-edge detect adds one cycle, so bit outputs change 3 cycles after the line edge.
- Acceptance to clk_oe = 1: 1 cycle.
- INHIBIT lasts exactly INHIBIT_CYCLES cycles.
- done_o fires 1 cycle after the accepting 0xFA, or after the final failure.
- cmd_valid_i while busy is ignored; it is held by the requester.
- rx_valid_i in the same cycle as watchdog expiry: the response byte wins.
- rx_valid_i outside WAIT_RESP: never consumed.

## Structure
- kbd_common holds:
  - PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE.
  - kbd_cmd_t struct: len, byte0, byte1.
  - kbd_seq_state_t enum: IDLE, INHIBIT, RTS, SHIFT, LINE_ACK, WAIT_RESP, DONE.
- Sub-module ps2_tx owns the synchronizer, edge detect, frame shifter and line-ack sample.
  - It takes a byte + start.
  - It returns sent/nack.
  - kbd_cmd_sequencer owns the command, response, retry and watchdog logic.

## Test plan
- One-byte command 0xFF. Device model clocks the frame, gives line-ack, replies 0xFA → data frame bits 1,1,1,1,1,1,1,1, parity 1; rx_consume_o pulses; done_o = 1, error_o = 0.
- Two-byte command 0xED, 0x07 → two frames. The second frame starts only after the first 0xFA; parity bits 1 then 0; one done_o, error = 0.
- Device replies 0xFE twice, then 0xFA → three identical frames of the same byte; done_o with error = 0.
- Device stays silent with TIMEOUT_CYCLES = 200, MAX_RETRIES = 2 → exactly 3 INHIBIT phases; done_o with error = 1; lines released.
- Scancode 0x1C arrives during WAIT_RESP, then 0xFA → 0x1C not consumed; 0xFA consumed; success.
- reset_i pulsed during the SHIFT phase → both OE outputs = 0 and cmd_ready_o = 1 on the next cycle; no done_o.
